m_axis_tx_sched: RTL and testbench

//  Shares one memory-to-AXIS streaming engine between NUM_REQ requesters.
//  - Arbitrates pending transfer requests and programs the engine's tx_count.
//  - Pulses tx_start, waits for tx_done, then signals completion to the winning requester.
//  - One transfer is in flight at a time. Sits between requester logic and the engine's control port.

---
 rtl/m_axis_tx_sched_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/m_axis_tx_sched.sv | 119 +++++++++++
 tb/tb_m_axis_tx_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/m_axis_tx_sched_pkg.sv
// rtl/m_axis_tx_sched_pkg.sv - shared types and constants for the tx scheduler
package m_axis_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  localparam int BUSY_GUARD_CYCLES = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Build option: TX_SCHED_FIXED_PRIO_EN selects fixed priority (lowest index wins).
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          any
);

  logic [IW-1:0] idx;

`ifdef TX_SCHED_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
`ifdef TX_SCHED_FIXED_PRIO_EN
      idx = IW'(i);
`else
      idx = IW'((int'(ptr) + i) % N);
`endif
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/m_axis_tx_sched.sv
// rtl/m_axis_tx_sched.sv - shares one memory-to-AXIS engine between NUM_REQ requesters
// Build option: TX_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration.
module m_axis_tx_sched
  import m_axis_tx_sched_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int ADDR_WIDTH = 5,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          m_axis_aclk,
  input  logic                          m_axis_aresetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_count,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            req_done,
  output logic                          tx_start,
  output logic [ADDR_WIDTH-1:0]         tx_count,
  input  logic                          tx_done,
  output logic                          busy,
  output logic [ID_WIDTH-1:0]           grant_id
);

  localparam int GUARD_W = $clog2(BUSY_GUARD_CYCLES + 1);

  sched_state_t          state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0] tx_count_q, tx_count_d;
  logic [GUARD_W-1:0]    guard_q, guard_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]    req_done_q, req_done_d;
  logic                  tx_start_q, tx_start_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [ID_WIDTH-1:0]   arb_id;
  logic                  arb_any;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    tx_count_d  = tx_count_q;
    guard_d     = guard_q;
    req_ready_d = '0;
    req_done_d  = '0;
    tx_start_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d     = START;
          grant_id_d  = arb_id;
          tx_count_d  = req_count[int'(arb_id)*ADDR_WIDTH +: ADDR_WIDTH];
          req_ready_d = arb_gnt;
          tx_start_d  = 1'b1;
        end
      end
      START: begin
        guard_d = '0;
        state_d = BUSY;
      end
      BUSY: begin
        // An idle engine may still present the previous tx_done level.
        if (guard_q < GUARD_W'(BUSY_GUARD_CYCLES)) begin
          guard_d = guard_q + 1'b1;
        end else if (tx_done) begin
          state_d    = DONE;
          req_done_d = NUM_REQ'(1) << grant_id_q;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef TX_SCHED_FIXED_PRIO_EN
        rr_ptr_d = '0;
`else
        rr_ptr_d = (int'(grant_id_q) == NUM_REQ - 1) ? '0 : grant_id_q + 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_aresetn) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      tx_count_q  <= '0;
      guard_q     <= '0;
      req_ready_q <= '0;
      req_done_q  <= '0;
      tx_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      tx_count_q  <= tx_count_d;
      guard_q     <= guard_d;
      req_ready_q <= req_ready_d;
      req_done_q  <= req_done_d;
      tx_start_q  <= tx_start_d;
    end
  end

  assign req_ready = req_ready_q;
  assign req_done  = req_done_q;
  assign tx_start  = tx_start_q;
  assign tx_count  = tx_count_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_m_axis_tx_sched.sv
// tb/tb_m_axis_tx_sched.sv - directed self-checking bench for m_axis_tx_sched
module tb_m_axis_tx_sched;

  localparam int NUM_REQ = 4;
  localparam int AW      = 5;
  localparam int IW      = 2;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*AW-1:0] req_count;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   req_done;
  logic                 tx_start;
  logic [AW-1:0]        tx_count;
  logic                 tx_done;
  logic                 busy;
  logic [IW-1:0]        grant_id;

  logic                 stuck_done;
  logic                 eng_done;
  logic                 eng_active;
  logic [AW-1:0]        eng_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  m_axis_tx_sched #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW)) dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (resetn),
    .req_valid      (req_valid),
    .req_count      (req_count),
    .req_ready      (req_ready),
    .req_done       (req_done),
    .tx_start       (tx_start),
    .tx_count       (tx_count),
    .tx_done        (tx_done),
    .busy           (busy),
    .grant_id       (grant_id)
  );

  // Engine model: count+1 beats after tx_start, then a held done level.
  always @(posedge clk) begin
    if (!resetn) begin
      eng_done   <= 1'b0;
      eng_active <= 1'b0;
      eng_cnt    <= '0;
    end else if (tx_start) begin
      eng_done   <= 1'b0;
      eng_active <= 1'b1;
      eng_cnt    <= tx_count;
    end else if (eng_active) begin
      if (eng_cnt == 0) begin
        eng_active <= 1'b0;
        eng_done   <= 1'b1;
      end else begin
        eng_cnt <= eng_cnt - 1'b1;
      end
    end
  end

  assign tx_done = eng_done | stuck_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_count(input int i, input logic [AW-1:0] v);
    req_count[i*AW +: AW] = v;
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (req_ready == 0 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_ready_seen"}, 32'(req_ready != 0), 32'd1);
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (req_done == 0 && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(req_done != 0), 32'd1);
  endtask

  int n;
  logic [IW-1:0] exp_gnt [5];
  logic seen_done;

  initial begin
    resetn     = 1'b0;
    req_valid  = 4'b1111;
    req_count  = '0;
    stuck_done = 1'b0;
    tick();
    tick();

    // 1: reset state, then first grant goes to requester 0
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_req_done",  32'(req_done),  32'h0);
    check("rst_tx_start",  32'(tx_start),  32'h0);
    check("rst_tx_count",  32'(tx_count),  32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_grant_id",  32'(grant_id),  32'h0);
    resetn = 1'b1;
    tick();
    check("t1_req_ready", 32'(req_ready), 32'h1);
    check("t1_tx_start",  32'(tx_start),  32'h1);
    check("t1_busy",      32'(busy),      32'h1);
    req_valid = 4'b0000;
    tick();
    check("t1_tx_start_pulse", 32'(tx_start),  32'h0);
    check("t1_ready_pulse",    32'(req_ready), 32'h0);
    wait_done("t1", n);
    check("t1_req_done", 32'(req_done), 32'h1);
    tick();
    check("t1_busy_drop", 32'(busy), 32'h0);

    // 2: single requester 2, count 7
    set_count(2, 5'd7);
    req_valid = 4'b0100;
    wait_ready("t2", n);
    check("t2_req_ready", 32'(req_ready), 32'h4);
    check("t2_grant_id",  32'(grant_id),  32'h2);
    check("t2_tx_count",  32'(tx_count),  32'h7);
    req_valid = 4'b0000;
    wait_done("t2", n);
    check("t2_latency",  32'(n),        32'd10);
    check("t2_req_done", 32'(req_done), 32'h4);
    tick();
    check("t2_done_pulse", 32'(req_done), 32'h0);
    check("t2_busy_drop",  32'(busy),     32'h0);
    check("t2_grant_hold", 32'(grant_id), 32'h2);

    // 3: all requesters continuously, from a fresh pointer
    resetn = 1'b0;
    tick();
    resetn    = 1'b1;
    req_count = '0;
    req_valid = 4'b1111;
`ifdef TX_SCHED_FIXED_PRIO_EN
    exp_gnt = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    exp_gnt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
    for (int k = 0; k < 5; k++) begin
      wait_ready("t3", n);
      check($sformatf("t3_grant_%0d", k), 32'(grant_id), 32'(exp_gnt[k]));
      wait_done("t3", n);
    end
    req_valid = 4'b0000;
    tick();

    // 4: tx_done stuck high is ignored while idle and for two BUSY cycles
    stuck_done = 1'b1;
    tick();
    tick();
    check("t4_idle_busy", 32'(busy),     32'h0);
    check("t4_idle_done", 32'(req_done), 32'h0);
    req_valid = 4'b1000;
    wait_ready("t4", n);
    check("t4_grant_id", 32'(grant_id), 32'h3);
    req_valid = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("t4_no_done_%0d", k), 32'(req_done), 32'h0);
      check($sformatf("t4_busy_%0d", k),    32'(busy),     32'h1);
    end
    tick();
    check("t4_req_done", 32'(req_done), 32'h8);
    stuck_done = 1'b0;
    tick();

    // 5: reset mid-BUSY aborts without completion
    set_count(1, 5'd20);
    req_valid = 4'b0010;
    wait_ready("t5", n);
    req_valid = 4'b0000;
    repeat (4) tick();
    check("t5_busy_before", 32'(busy), 32'h1);
    resetn = 1'b0;
    tick();
    check("t5_busy",     32'(busy),     32'h0);
    check("t5_req_done", 32'(req_done), 32'h0);
    check("t5_tx_start", 32'(tx_start), 32'h0);
    check("t5_grant_id", 32'(grant_id), 32'h0);
    check("t5_tx_count", 32'(tx_count), 32'h0);
    resetn    = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      seen_done = seen_done | (req_done != 0);
    end
    check("t5_no_done_after_rst", 32'(seen_done), 32'h0);
    set_count(2, 5'd1);
    req_valid = 4'b0100;
    wait_ready("t5b", n);
    check("t5b_grant_id", 32'(grant_id), 32'h2);
    req_valid = 4'b0000;
    wait_done("t5b", n);
    check("t5b_latency",  32'(n),        32'd4);
    check("t5b_req_done", 32'(req_done), 32'h4);
    tick();

    // 6: req_count change after acceptance is ignored
    set_count(1, 5'd3);
    req_valid = 4'b0010;
    wait_ready("t6", n);
    check("t6_tx_count_acc", 32'(tx_count), 32'h3);
    req_valid = 4'b0000;
    tick();
    set_count(1, 5'd9);
    tick();
    check("t6_tx_count_busy", 32'(tx_count), 32'h3);
    wait_done("t6", n);
    check("t6_latency",      32'(n),        32'd4);
    check("t6_req_done",     32'(req_done), 32'h2);
    check("t6_tx_count_end", 32'(tx_count), 32'h3);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
